// File: rtl/vsa16_dmem_unit.sv
// vsa16_dmem_unit: data-side memory unit for the VSA16 core.
// Local word RAM plus an MMIO page at 0xFFxx holding the TX FIFO, the STATUS
// register and an optional free-running TIMER.
// Build option: define VSA16_DMEM_TIMER_EN to implement the TIMER counter;
// without it, TIMER reads 0 and no counter flops exist.
module vsa16_dmem_unit #(
  parameter int RAM_AW     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        wr,
  output logic [15:0] rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int         RAM_WORDS  = 2 ** RAM_AW;
  localparam int         PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C    = 4'(FIFO_DEPTH);
  localparam logic [6:0] OFF_TXDATA = 7'h00;
  localparam logic [6:0] OFF_STATUS = 7'h01;
  localparam logic [6:0] OFF_TIMER  = 7'h02;

  logic [15:0]       ram_q  [RAM_WORDS];
  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [15:0]       fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [3:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       timer_val;

  logic              is_mmio;
  logic [6:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              full;
  logic              push_req;
  logic              push_acc;
  logic              pop;
  logic              status_wr;
  logic              unused_addr0;

  // Byte address bit 0 has no meaning for a word-only memory.
  assign unused_addr0 = addr[0];

  assign is_mmio  = (addr[15:8] == 8'hFF);
  assign mmio_off = addr[7:1];
  assign ram_idx  = addr[RAM_AW:1];

  // Address decode and FIFO handshake qualifiers
  always_comb begin
    ram_we    = reset_n && wr && !is_mmio;
    full      = (count_q == DEPTH_C);
    tx_valid  = (count_q != 4'd0);
    pop       = tx_valid && tx_ready;
    push_req  = wr && is_mmio && (mmio_off == OFF_TXDATA);
    status_wr = wr && is_mmio && (mmio_off == OFF_STATUS);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_acc  = push_req && (!full || pop);
  end

  // FIFO next-state: storage, pointers, occupancy and sticky overflow
  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_acc) begin
      fifo_d[wr_ptr_q] = wdata;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_acc && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push_acc) begin
      count_d = count_q - 4'd1;
    end
    if (status_wr) begin
      ovf_d = 1'b0;
    end
    // Overflow takes priority over a clear landing in the same cycle.
    if (push_req && !push_acc) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO control registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage is not cleared; it only updates outside reset
  always_ff @(posedge clock) begin
    if (reset_n) begin
      fifo_q <= fifo_d;
    end
  end

  // Word RAM, contents survive reset
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata;
    end
  end

`ifdef VSA16_DMEM_TIMER_EN
  logic [15:0] timer_q, timer_d;

  // Free-running cycle counter, wraps naturally at 16 bits
  always_comb begin
    timer_d = timer_q + 16'd1;
  end

  // Timer register, cleared while in reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer_q <= 16'h0000;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = 16'h0000;
`endif

  // Head word is masked to 0 whenever the FIFO is empty
  always_comb begin
    tx_data = tx_valid ? fifo_q[rd_ptr_q] : 16'h0000;
  end

  // Combinational load path: RAM or MMIO register
  always_comb begin
    rdata = 16'h0000;
    if (is_mmio) begin
      case (mmio_off)
        OFF_STATUS: rdata = {10'b0, ovf_q, full, count_q};
        OFF_TIMER:  rdata = timer_val;
        default:    rdata = 16'h0000;
      endcase
    end else begin
      rdata = ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_vsa16_dmem_unit.sv
// tb_vsa16_dmem_unit: table-driven RAM/MMIO checks plus a TX FIFO scoreboard.
module tb_vsa16_dmem_unit;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic [15:0] rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total;
  int bad;
  logic mon_en;
  logic [15:0] sbq[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] w;
    logic        we;
    logic [15:0] exp;
    logic        chk;
  } vec_t;

  vec_t vec[$];

  vsa16_dmem_unit #(.RAM_AW(7), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr     (addr),
    .wdata    (wdata),
    .wr       (wr),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: predicts FIFO pushes/pops and compares the head as it leaves
  always @(negedge clock) begin
    logic exp_valid;
    logic do_pop;
    logic is_push;
    if (mon_en) begin
      if (!reset_n) begin
        sbq.delete();
      end else begin
        exp_valid = (sbq.size() != 0);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_valid});
        do_pop = exp_valid && tx_ready;
        if (do_pop) begin
          chk("tx_data", {16'b0, tx_data}, {16'b0, sbq[0]});
        end else if (!exp_valid) begin
          chk("tx_data_idle", {16'b0, tx_data}, 32'h0);
        end
        is_push = wr && (addr[15:8] == 8'hFF) && (addr[7:1] == 7'h00);
        if (is_push && ((sbq.size() < DEPTH) || do_pop)) begin
          sbq.push_back(wdata);
        end
        if (do_pop) begin
          void'(sbq.pop_front());
        end
        chk("inv_count_le_depth", {31'b0, (dut.count_q <= 4'(DEPTH))}, 32'h1);
        chk("inv_valid_eq_cnt", {31'b0, tx_valid}, {31'b0, (dut.count_q != 4'd0)});
      end
    end
  end

  initial begin
    logic [15:0] drain_exp [4];
    logic        found;
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    wr       = 1'b0;
    wdata    = 16'h0000;
    addr     = 16'hFF02;
    tx_ready = 1'b0;

    vec.push_back('{16'h0010, 16'h1111, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'h0010, 16'hBEEF, 1'b1, 16'h1111, 1'b1});
    vec.push_back('{16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b1});
    vec.push_back('{16'h0011, 16'h0000, 1'b0, 16'hBEEF, 1'b1});
    vec.push_back('{16'h0002, 16'h1234, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'h0102, 16'h0000, 1'b0, 16'h1234, 1'b1});
    vec.push_back('{16'h0003, 16'h0000, 1'b0, 16'h1234, 1'b1});
    vec.push_back('{16'h00FE, 16'h5A5A, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'h01FE, 16'h0000, 1'b0, 16'h5A5A, 1'b1});
    vec.push_back('{16'h0100, 16'h7777, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'h0000, 16'h0000, 1'b0, 16'h7777, 1'b1});
    vec.push_back('{16'h0008, 16'h4444, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'hFF08, 16'h9999, 1'b1, 16'h0000, 1'b1});
    vec.push_back('{16'h0008, 16'h0000, 1'b0, 16'h4444, 1'b1});
    vec.push_back('{16'hFE10, 16'hCAFE, 1'b1, 16'h0000, 1'b0});
    vec.push_back('{16'h0010, 16'h0000, 1'b0, 16'hCAFE, 1'b1});
    vec.push_back('{16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b1});
    vec.push_back('{16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b1});
    vec.push_back('{16'hFF06, 16'h0000, 1'b0, 16'h0000, 1'b1});

    // Reset state
    step();
    step();
    @(negedge clock);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {16'b0, tx_data}, 32'h0);
    chk("rst_status", {16'b0, rdata}, 32'h0);
    mon_en = 1'b1;
    step();

    // Release reset and sample TIMER 10 cycles later
    reset_n = 1'b1;
    addr    = 16'hFF04;
    #1;
    chk("timer_at_release", {16'b0, rdata}, 32'h0);
    repeat (10) step();
    @(negedge clock);
`ifdef VSA16_DMEM_TIMER_EN
    chk("timer_10", {16'b0, rdata}, 32'd10);
`else
    chk("timer_disabled", {16'b0, rdata}, 32'h0);
`endif
    step();

    // RAM / MMIO decode vectors
    for (int i = 0; i < vec.size(); i++) begin
      addr  = vec[i].a;
      wdata = vec[i].w;
      wr    = vec[i].we;
      @(negedge clock);
      if (vec[i].chk) begin
        chk($sformatf("vec%0d_rdata", i), {16'b0, rdata}, {16'b0, vec[i].exp});
      end
      step();
    end
    wr = 1'b0;

    // Overflow: push 1..5 with the consumer stalled
    tx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      addr  = 16'hFF00;
      wdata = 16'(k);
      wr    = 1'b1;
      step();
    end
    wr   = 1'b0;
    addr = 16'hFF02;
    @(negedge clock);
    chk("status_full_ovf", {16'b0, rdata}, 32'h0034);
    step();
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("drain1_%0d", k), {16'b0, tx_data}, k);
      step();
    end
    @(negedge clock);
    chk("drain1_empty", {31'b0, tx_valid}, 32'h0);
    chk("status_ovf_only", {16'b0, rdata}, 32'h0020);
    step();
    tx_ready = 1'b0;

    // STATUS write clears ovf
    addr  = 16'hFF02;
    wdata = 16'hFFFF;
    wr    = 1'b1;
    step();
    wr = 1'b0;
    @(negedge clock);
    chk("status_cleared", {16'b0, rdata}, 32'h0);
    step();

    // Full FIFO: simultaneous push and pop keeps count and does not overflow
    drain_exp[0] = 16'h0022;
    drain_exp[1] = 16'h0033;
    drain_exp[2] = 16'h0044;
    drain_exp[3] = 16'hAAAA;
    for (int k = 1; k <= 4; k++) begin
      addr  = 16'hFF00;
      wdata = 16'(k * 16'h0011);
      wr    = 1'b1;
      step();
    end
    tx_ready = 1'b1;
    wdata    = 16'hAAAA;
    step();
    wr       = 1'b0;
    tx_ready = 1'b0;
    addr     = 16'hFF02;
    @(negedge clock);
    chk("status_full_noovf", {16'b0, rdata}, 32'h0014);
    step();
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("drain2_%0d", k), {16'b0, tx_data}, {16'b0, drain_exp[k]});
      step();
    end
    @(negedge clock);
    chk("drain2_empty", {31'b0, tx_valid}, 32'h0);
    step();
    tx_ready = 1'b0;

    // Reset with 3 entries in flight
    for (int k = 0; k < 3; k++) begin
      addr  = 16'hFF00;
      wdata = 16'h0101 + 16'(k);
      wr    = 1'b1;
      step();
    end
    wr   = 1'b0;
    addr = 16'hFF02;
    @(negedge clock);
    chk("status_cnt3", {16'b0, rdata}, 32'h0003);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_status", {16'b0, rdata}, 32'h0);
    chk("post_rst_valid", {31'b0, tx_valid}, 32'h0);
    step();
    addr = 16'h0010;
    @(negedge clock);
    chk("ram_retained", {16'b0, rdata}, 32'hCAFE);
    step();
    addr = 16'hFF04;
    @(negedge clock);
`ifdef VSA16_DMEM_TIMER_EN
    chk("timer_restart", {16'b0, rdata}, 32'd2);
`else
    chk("timer_restart_dis", {16'b0, rdata}, 32'h0);
`endif

`ifdef VSA16_DMEM_TIMER_EN
    // Run the timer up to 0xFFFF and watch it wrap
    found = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      if (rdata == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
      step();
      @(negedge clock);
    end
    chk("timer_reach_ffff", {31'b0, found}, 32'h1);
    step();
    @(negedge clock);
    chk("timer_wrap", {16'b0, rdata}, 32'h0);
`else
    found = 1'b0;
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
